mem_port_arbiter: RTL and testbench

- Shares one memory read/write port between two requesters: the data side (req_*) and the instruction-fetch side (fetch_*).
- Sits between the cache/fetch logic and the memory controller port (mem_*).
- Uses round-robin arbitration and allows one outstanding read.
- Routes each read response back to the requester that issued the read.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter that shares one memory read/write port
// between the data side (req_*) and the instruction-fetch side (fetch_*).
module mem_port_arbiter #(
   parameter int  mem_depth  = 32,
   parameter int  data_width = 32,
   localparam int AW = $clog2(mem_depth)
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [AW-1:0]         req_raddr,
   input  logic                  req_ren,
   output logic                  req_rready,
   output logic [data_width-1:0] req_rdata,
   output logic                  req_rdata_valid,
   input  logic [AW-1:0]         req_waddr,
   input  logic                  req_wen,
   output logic                  req_wready,
   input  logic [data_width-1:0] req_wdata,

   input  logic [AW-1:0]         fetch_raddr,
   input  logic                  fetch_ren,
   output logic                  fetch_rready,
   output logic [data_width-1:0] fetch_rdata,
   output logic                  fetch_rdata_valid,
   input  logic [AW-1:0]         fetch_waddr,
   input  logic                  fetch_wen,
   output logic                  fetch_wready,
   input  logic [data_width-1:0] fetch_wdata,

   output logic [AW-1:0]         mem_raddr,
   output logic                  mem_ren,
   input  logic                  mem_rready,
   input  logic [data_width-1:0] mem_rdata,
   input  logic                  mem_rdata_valid,
   output logic [AW-1:0]         mem_waddr,
   output logic                  mem_wen,
   input  logic                  mem_wready,
   output logic [data_width-1:0] mem_wdata,

   output logic                  err_spurious
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] RD_WAIT = 1'b1;

   logic [0:0] state;
   logic       rd_owner;     // 0 = req, 1 = fetch
   logic       last_owner;   // 0 = req, 1 = fetch
   logic       err_q;

   logic req_any, fetch_any;
   logic grant_valid, grant_fetch;
   logic sel_wen, sel_ren;
   logic rd_xfer, wr_xfer;
   logic resp;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      req_any     = req_ren | req_wen;
      fetch_any   = fetch_ren | fetch_wen;
      grant_valid = 1'b0;
      grant_fetch = 1'b0;
      if (state == IDLE && !rst) begin
         grant_valid = req_any | fetch_any;
         // On contention the side that did not complete the last transfer wins.
         grant_fetch = (req_any && fetch_any) ? ~last_owner : fetch_any;
      end

      sel_wen = grant_fetch ? fetch_wen : req_wen;
      sel_ren = grant_fetch ? fetch_ren : req_ren;

      // A pending write beats a pending read within the granted requester.
      mem_wen   = grant_valid & sel_wen;
      mem_ren   = grant_valid & ~sel_wen & sel_ren;
      mem_waddr = grant_fetch ? fetch_waddr : req_waddr;
      mem_wdata = grant_fetch ? fetch_wdata : req_wdata;
      mem_raddr = grant_fetch ? fetch_raddr : req_raddr;

      req_wready   = mem_wen & ~grant_fetch & mem_wready;
      fetch_wready = mem_wen &  grant_fetch & mem_wready;
      req_rready   = mem_ren & ~grant_fetch & mem_rready;
      fetch_rready = mem_ren &  grant_fetch & mem_rready;

      rd_xfer = mem_ren & mem_rready;
      wr_xfer = mem_wen & mem_wready;

      resp              = (state == RD_WAIT) & mem_rdata_valid & ~rst;
      req_rdata_valid   = resp & ~rd_owner;
      fetch_rdata_valid = resp &  rd_owner;
      req_rdata         = mem_rdata;
      fetch_rdata       = mem_rdata;

      err_spurious = err_q & ~rst;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_owner   <= 1'b0;
         last_owner <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_rdata_valid) err_q <= 1'b1;
               // A stalled grant leaves the rotation where it was.
               if (rd_xfer || wr_xfer) last_owner <= grant_fetch;
               if (rd_xfer) begin
                  state    <= RD_WAIT;
                  rd_owner <= grant_fetch;
               end
            end
            RD_WAIT: begin
               if (mem_rdata_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester and memory agents driven by
// $urandom, outputs compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int MEM_DEPTH = 32;
   localparam int DW        = 32;
   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int N_CYCLES  = 4000;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] req_raddr, req_waddr, fetch_raddr, fetch_waddr;
   logic          req_ren, req_wen, fetch_ren, fetch_wen;
   logic          req_rready, req_wready, fetch_rready, fetch_wready;
   logic [DW-1:0] req_rdata, fetch_rdata, req_wdata, fetch_wdata;
   logic          req_rdata_valid, fetch_rdata_valid;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic          mem_ren, mem_rready, mem_rdata_valid, mem_wen, mem_wready;
   logic [DW-1:0] mem_rdata, mem_wdata;
   logic          err_spurious;

   // Requester agents, index 0 = req, 1 = fetch; each holds its request until accepted.
   bit            pend_r[2];
   bit            pend_w[2];
   logic [AW-1:0] ra[2];
   logic [AW-1:0] wa[2];
   logic [DW-1:0] wd[2];

   assign req_ren     = pend_r[0];
   assign req_raddr   = ra[0];
   assign req_wen     = pend_w[0];
   assign req_waddr   = wa[0];
   assign req_wdata   = wd[0];
   assign fetch_ren   = pend_r[1];
   assign fetch_raddr = ra[1];
   assign fetch_wen   = pend_w[1];
   assign fetch_waddr = wa[1];
   assign fetch_wdata = wd[1];

   mem_port_arbiter #(.mem_depth(MEM_DEPTH), .data_width(DW)) dut (
      .clk(clk), .rst(rst),
      .req_raddr(req_raddr), .req_ren(req_ren), .req_rready(req_rready),
      .req_rdata(req_rdata), .req_rdata_valid(req_rdata_valid),
      .req_waddr(req_waddr), .req_wen(req_wen), .req_wready(req_wready),
      .req_wdata(req_wdata),
      .fetch_raddr(fetch_raddr), .fetch_ren(fetch_ren), .fetch_rready(fetch_rready),
      .fetch_rdata(fetch_rdata), .fetch_rdata_valid(fetch_rdata_valid),
      .fetch_waddr(fetch_waddr), .fetch_wen(fetch_wen), .fetch_wready(fetch_wready),
      .fetch_wdata(fetch_wdata),
      .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wready(mem_wready),
      .mem_wdata(mem_wdata),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: a read is either outstanding (with a known owner) or not,
   // plus the identity of whoever completed the last transfer and a sticky error flag.
   bit m_busy, m_owner, m_last, m_err;
   int resp_timer;   // memory agent: cycles until the outstanding response is returned

   initial begin
      bit want[2];
      bit win, wr_go, rd_go;
      bit e_wen, e_ren;
      bit e_rready[2], e_wready[2], e_valid[2];

      rst = 1'b1;
      mem_rready = 1'b0; mem_wready = 1'b0;
      mem_rdata = '0; mem_rdata_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pend_r[i] = 1'b0; pend_w[i] = 1'b0;
         ra[i] = '0; wa[i] = '0; wd[i] = '0;
      end
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_err = 1'b0;
      resp_timer = 0;

      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!pend_w[i] && $urandom_range(0, 99) < 30) begin
               pend_w[i] = 1'b1;
               wa[i] = AW'($urandom_range(0, MEM_DEPTH - 1));
               wd[i] = $urandom;
            end
            if (!pend_r[i] && $urandom_range(0, 99) < 55) begin
               pend_r[i] = 1'b1;
               ra[i] = AW'($urandom_range(0, MEM_DEPTH - 1));
            end
         end
         rst        = (cyc < 2) || ($urandom_range(0, 199) == 0);
         mem_rready = ($urandom_range(0, 3) != 0);
         mem_wready = ($urandom_range(0, 3) != 0);
         mem_rdata  = $urandom;
         // Responses arrive on schedule; occasionally an unsolicited one is injected while idle.
         mem_rdata_valid = (resp_timer == 1) ||
                           (resp_timer == 0 && !m_busy && $urandom_range(0, 59) == 0);

         #1;
         want[0] = pend_r[0] | pend_w[0];
         want[1] = pend_r[1] | pend_w[1];
         win = 1'b0; wr_go = 1'b0; rd_go = 1'b0; e_wen = 1'b0; e_ren = 1'b0;
         for (int i = 0; i < 2; i++) begin
            e_rready[i] = 1'b0; e_wready[i] = 1'b0; e_valid[i] = 1'b0;
         end
         if (!rst && !m_busy && (want[0] || want[1])) begin
            win = (want[0] && want[1]) ? !m_last : want[1];
            if (pend_w[win]) begin
               e_wen = 1'b1; e_wready[win] = mem_wready; wr_go = mem_wready;
            end else begin
               e_ren = 1'b1; e_rready[win] = mem_rready; rd_go = mem_rready;
            end
         end
         if (!rst && m_busy && mem_rdata_valid) e_valid[m_owner] = 1'b1;

         check("mem_wen",           32'(mem_wen),           32'(e_wen));
         check("mem_ren",           32'(mem_ren),           32'(e_ren));
         check("req_wready",        32'(req_wready),        32'(e_wready[0]));
         check("fetch_wready",      32'(fetch_wready),      32'(e_wready[1]));
         check("req_rready",        32'(req_rready),        32'(e_rready[0]));
         check("fetch_rready",      32'(fetch_rready),      32'(e_rready[1]));
         check("req_rdata_valid",   32'(req_rdata_valid),   32'(e_valid[0]));
         check("fetch_rdata_valid", 32'(fetch_rdata_valid), 32'(e_valid[1]));
         check("err_spurious",      32'(err_spurious),      32'(m_err && !rst));
         check("req_rdata",         req_rdata,              mem_rdata);
         check("fetch_rdata",       fetch_rdata,            mem_rdata);
         if (e_wen) begin
            check("mem_waddr", 32'(mem_waddr), 32'(wa[win]));
            check("mem_wdata", mem_wdata,      wd[win]);
         end
         if (e_ren) check("mem_raddr", 32'(mem_raddr), 32'(ra[win]));

         @(posedge clk);
         #1;
         if (rst) begin
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_err = 1'b0;
         end else if (m_busy) begin
            if (mem_rdata_valid) m_busy = 1'b0;
         end else begin
            if (mem_rdata_valid) m_err = 1'b1;
            if (wr_go || rd_go) m_last = win;
            if (rd_go) begin
               m_busy = 1'b1; m_owner = win;
            end
         end
         if (wr_go) pend_w[win] = 1'b0;
         if (rd_go) pend_r[win] = 1'b0;
         if (resp_timer > 0) resp_timer--;
         if (rd_go) resp_timer = $urandom_range(1, 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
